// File: rtl/data_cell_if.sv
// Command/status bundle between the instruction sequencer and the data cell unit.
// The sequencer drives the master side; the data cell unit sits on the slave side.
`timescale 1ns/1ps
interface data_cell_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     cmd_valid;
    logic [2:0]               cmd;
    logic                     cmd_ready;
    logic [DATA_WIDTH-1:0]    data;
    logic                     zero;
    logic                     dirty;
    logic                     err;

    modport master (
        output address, cmd_valid, cmd,
        input  cmd_ready, data, zero, dirty, err
    );

    modport slave (
        input  address, cmd_valid, cmd,
        output cmd_ready, data, zero, dirty, err
    );
endinterface

// File: rtl/data_cell_unit.sv
// Tape data RAM with a single write-back cached counter.
// Clears the tape on reset and executes cell commands over a valid/ready handshake.
`timescale 1ns/1ps
module data_cell_unit #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned MAX_ADDRESS   = 29999,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MAX_DATA      = 255,
    parameter bit          WRAP          = 1'b1
) (
    input logic        clock,
    input logic        rst,
    data_cell_if.slave bus
);
    localparam int unsigned RAM_DEPTH = MAX_ADDRESS + 1;
    localparam int unsigned RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WB, S_RD} state_t;
    typedef enum logic [2:0] {
        C_NOP, C_LOAD, C_STORE, C_INC, C_DEC, C_CLEAR, C_FLUSH, C_RSVD
    } cmd_t;

    state_t                   state;
    logic [RAM_AW-1:0]        init_addr;
    logic [ADDRESS_WIDTH-1:0] ca;
    logic [ADDRESS_WIDTH-1:0] pend_addr;
    cmd_t                     pend_op;
    logic [DATA_WIDTH-1:0]    cnt;
    logic                     val;
    logic                     dirty_q;
    logic                     zero_q;
    logic                     ready_q;
    logic                     err_q;

    logic [DATA_WIDTH-1:0]    mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0]    ram_q;

    cmd_t                     cmd_c;
    logic                     accept_c;
    logic                     hit_c;
    logic                     in_range_c;
    logic                     addr_cmd_c;
    logic [DATA_WIDTH-1:0]    hit_val_c;
    logic [DATA_WIDTH-1:0]    rd_val_c;
    logic                     ram_we_c;
    logic [RAM_AW-1:0]        ram_waddr_c;
    logic [DATA_WIDTH-1:0]    ram_wdata_c;
    logic [RAM_AW-1:0]        ram_raddr_c;

    // Counter update for one operation; saturating or modulo depending on WRAP.
    function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] v,
                                                   input cmd_t op);
        logic [DATA_WIDTH-1:0] r;
        r = v;
        case (op)
            C_INC: begin
                if (v == DATA_WIDTH'(MAX_DATA)) r = WRAP ? '0 : v;
                else                            r = v + DATA_WIDTH'(1);
            end
            C_DEC: begin
                if (v == '0) r = WRAP ? DATA_WIDTH'(MAX_DATA) : v;
                else         r = v - DATA_WIDTH'(1);
            end
            C_CLEAR: r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    assign cmd_c      = cmd_t'(bus.cmd);
    assign accept_c   = bus.cmd_valid & ready_q;
    assign hit_c      = val & (bus.address == ca);
    assign in_range_c = (bus.address <= ADDRESS_WIDTH'(MAX_ADDRESS));
    assign addr_cmd_c = (cmd_c == C_LOAD) || (cmd_c == C_STORE) || (cmd_c == C_INC) ||
                        (cmd_c == C_DEC)  || (cmd_c == C_CLEAR);
    assign hit_val_c  = step(cnt, cmd_c);
    assign rd_val_c   = step(ram_q, pend_op);

    // RAM port steering; writes are suppressed while reset is held so an aborted WB is dropped.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = '0;
        ram_wdata_c = cnt;
        ram_raddr_c = RAM_AW'(bus.address);
        if (rst) begin
            case (state)
                S_INIT: begin
                    ram_we_c    = 1'b1;
                    ram_waddr_c = init_addr;
                    ram_wdata_c = '0;
                end
                S_IDLE: begin
                    if (accept_c && cmd_c == C_STORE && in_range_c) begin
                        ram_we_c    = 1'b1;
                        ram_waddr_c = RAM_AW'(bus.address);
                    end else if (accept_c && cmd_c == C_FLUSH && dirty_q) begin
                        ram_we_c    = 1'b1;
                        ram_waddr_c = RAM_AW'(ca);
                    end
                end
                S_WB: begin
                    ram_we_c    = 1'b1;
                    ram_waddr_c = RAM_AW'(ca);
                    ram_raddr_c = RAM_AW'(pend_addr);
                end
                S_RD:    ram_raddr_c = RAM_AW'(pend_addr);
                default: ram_we_c = 1'b0;
            endcase
        end
    end

    // Single-port-write, synchronous-read tape storage.
    always_ff @(posedge clock) begin
        if (ram_we_c) mem[ram_waddr_c] <= ram_wdata_c;
        ram_q <= mem[ram_raddr_c];
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state     <= S_INIT;
            init_addr <= '0;
            ca        <= '0;
            pend_addr <= '0;
            pend_op   <= C_NOP;
            cnt       <= '0;
            val       <= 1'b0;
            dirty_q   <= 1'b0;
            zero_q    <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_INIT: begin
                    if (init_addr == RAM_AW'(MAX_ADDRESS)) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        val     <= 1'b0;
                        dirty_q <= 1'b0;
                    end else begin
                        init_addr <= init_addr + RAM_AW'(1);
                    end
                end
                S_IDLE: begin
                    if (accept_c) begin
                        if (addr_cmd_c && !in_range_c) begin
                            err_q <= 1'b1;
                        end else begin
                            case (cmd_c)
                                C_LOAD, C_INC, C_DEC: begin
                                    if (cmd_c != C_LOAD && hit_c) begin
                                        cnt     <= hit_val_c;
                                        zero_q  <= (hit_val_c == '0);
                                        dirty_q <= 1'b1;
                                    end else begin
                                        pend_op   <= cmd_c;
                                        pend_addr <= bus.address;
                                        ready_q   <= 1'b0;
                                        state     <= (!hit_c && dirty_q) ? S_WB : S_RD;
                                    end
                                end
                                C_CLEAR: begin
                                    if (hit_c || !dirty_q) begin
                                        cnt     <= '0;
                                        zero_q  <= 1'b1;
                                        dirty_q <= 1'b1;
                                        ca      <= bus.address;
                                        val     <= 1'b1;
                                    end else begin
                                        pend_op   <= cmd_c;
                                        pend_addr <= bus.address;
                                        ready_q   <= 1'b0;
                                        state     <= S_WB;
                                    end
                                end
                                C_STORE: begin
                                    dirty_q <= 1'b0;
                                    ca      <= bus.address;
                                    val     <= 1'b1;
                                end
                                C_FLUSH: dirty_q <= 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
                S_WB: begin
                    dirty_q <= 1'b0;
                    if (pend_op == C_CLEAR) begin
                        cnt     <= '0;
                        zero_q  <= 1'b1;
                        dirty_q <= 1'b1;
                        ca      <= pend_addr;
                        val     <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    cnt     <= rd_val_c;
                    zero_q  <= (rd_val_c == '0);
                    dirty_q <= (pend_op != C_LOAD);
                    ca      <= pend_addr;
                    val     <= 1'b1;
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state     <= S_INIT;
                    init_addr <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.data      = cnt;
    assign bus.zero      = zero_q;
    assign bus.dirty     = dirty_q;
    assign bus.err       = err_q;
endmodule
